// File: rtl/hilo_muldiv_controller.sv
// rtl/hilo_muldiv_controller.sv - multi-cycle mul/div sequencer owning all Hi/Lo register file writes
module hilo_muldiv_controller (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] HiIn,
    input  logic [31:0] LoIn,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic        WriteEn,
    output logic [31:0] WriteHiData,
    output logic [31:0] WriteLoData
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        nowrite_q, nowrite_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic        we_q, we_d;

    logic        signed_in;
    logic        div_in;
    logic        div_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_part;
    logic        div_ge;
    logic [31:0] div_upper;
    logic [63:0] div_next;

    always_comb begin
        signed_in = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        div_in    = (Op == OP_DIV) || (Op == OP_DIVU);
        div_op    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        a_mag     = (signed_in && A[31]) ? (~A + 32'd1) : A;
        b_mag     = (signed_in && B[31]) ? (~B + 32'd1) : B;

        // Multiply: work = {partial product, remaining multiplier bits}, shifted right each step
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};

        // Divide: work = {remainder, dividend/quotient}; the 33-bit window keeps the carried-out bit
        div_part  = work_q[63:31];
        div_ge    = (div_part >= {1'b0, b_q});
        div_upper = div_ge ? (div_part[31:0] - b_q) : div_part[31:0];
        div_next  = {div_upper, work_q[30:0], div_ge};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        nowrite_d = nowrite_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        we_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d      = Op;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_d     = signed_in && (A[31] ^ B[31]);
                    rneg_d    = signed_in && A[31];
                    cnt_d     = 5'd0;
                    busy_d    = 1'b1;
                    nowrite_d = 1'b0;
                    work_d    = div_in ? {32'd0, a_mag} : {32'd0, b_mag};
                    if ((Op == OP_MTHI) || (Op == OP_MTLO)) begin
                        state_d = S_WRITE;
                        done_d  = 1'b1;
                        we_d    = 1'b1;
                    end else if (div_in && (B == 32'd0)) begin
                        state_d   = S_WRITE;
                        done_d    = 1'b1;
                        dbz_d     = 1'b1;
                        nowrite_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                work_d = div_op ? div_next : mul_next;
                if (cnt_q == 5'd31) begin
                    state_d = S_WRITE;
                    cnt_d   = 5'd0;
                    done_d  = 1'b1;
                    we_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            work_q    <= 64'd0;
            cnt_q     <= 5'd0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            nowrite_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            nowrite_q <= nowrite_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            we_q      <= we_d;
        end
    end

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] hilo_in;
    logic [63:0] result;

    // Hi/Lo inputs are folded in combinationally while in WRITE; nothing else can change them
    always_comb begin
        prod    = neg_q ? (~work_q + 64'd1) : work_q;
        quot    = neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem     = rneg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
        hilo_in = {HiIn, LoIn};
        result  = hilo_in;
        case (op_q)
            OP_MULT, OP_MULTU: result = prod;
            OP_DIV, OP_DIVU:   result = nowrite_q ? hilo_in : {rem, quot};
            OP_MADD:           result = hilo_in + prod;
            OP_MSUB:           result = hilo_in - prod;
            OP_MTHI:           result = {a_q, LoIn};
            OP_MTLO:           result = {HiIn, a_q};
            default:           result = hilo_in;
        endcase
    end

    assign WriteHiData = (state_q == S_WRITE) ? result[63:32] : 32'd0;
    assign WriteLoData = (state_q == S_WRITE) ? result[31:0] : 32'd0;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign DivByZero   = dbz_q;
    assign WriteEn     = we_q;

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// tb/tb_hilo_muldiv_controller.sv - directed self-checking bench for hilo_muldiv_controller
module tb_hilo_muldiv_controller;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] HiIn;
    logic [31:0] LoIn;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic        WriteEn;
    logic [31:0] WriteHiData;
    logic [31:0] WriteLoData;

    logic [31:0] hi_rf = 32'd0;
    logic [31:0] lo_rf = 32'd0;

    int checks = 0;
    int errors = 0;
    int n;
    int we_seen;

    hilo_muldiv_controller dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiIn(HiIn), .LoIn(LoIn), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .WriteEn(WriteEn), .WriteHiData(WriteHiData), .WriteLoData(WriteLoData)
    );

    always #5 Clk = ~Clk;

    assign HiIn = hi_rf;
    assign LoIn = lo_rf;

    always @(posedge Clk) begin
        if (WriteEn) begin
            hi_rf <= WriteHiData;
            lo_rf <= WriteLoData;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            cycles++;
            if (Done) break;
        end
    endtask

    task automatic chk_write(input string tag, input int cycles, input int exp_cycles,
                             input logic exp_we, input logic exp_dbz,
                             input logic [31:0] hi, input logic [31:0] lo);
        chk({tag, "_lat"}, 64'(cycles), 64'(exp_cycles));
        chk({tag, "_done"}, {63'd0, Done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
        chk({tag, "_we"}, {63'd0, WriteEn}, {63'd0, exp_we});
        chk({tag, "_dbz"}, {63'd0, DivByZero}, {63'd0, exp_dbz});
        if (exp_we) chk({tag, "_data"}, {WriteHiData, WriteLoData}, {hi, lo});
    endtask

    task automatic chk_after(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        @(negedge Clk);
        chk({tag, "_idle"}, {60'd0, Busy, Done, WriteEn, DivByZero}, 64'd0);
        chk({tag, "_zero"}, {WriteHiData, WriteLoData}, 64'd0);
        chk({tag, "_rf"}, {hi_rf, lo_rf}, {hi, lo});
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_outs", {60'd0, Busy, Done, WriteEn, DivByZero}, 64'd0);
        chk("reset_data", {WriteHiData, WriteLoData}, 64'd0);
        Rst = 1'b0;

        // MULT -3 * 5
        do_accept(3'b000, 32'hFFFF_FFFD, 32'd5);
        @(negedge Clk);
        chk("mult_calc_busy", {62'd0, Busy, WriteEn}, 64'd2);
        wait_done(n);
        chk_write("mult", n + 1, 33, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        chk_after("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        do_accept(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk_write("multu", n, 33, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        chk_after("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        do_accept(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk_write("div", n, 33, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk_after("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_accept(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk_write("divwrap", n, 33, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000);
        chk_after("divwrap", 32'h0000_0000, 32'h8000_0000);

        do_accept(3'b110, 32'd31, 32'd0);
        wait_done(n);
        chk_write("mthi", n, 1, 1'b1, 1'b0, 32'd31, 32'h8000_0000);
        chk_after("mthi", 32'd31, 32'h8000_0000);

        do_accept(3'b111, 32'hFFFF_FFE0, 32'd0);
        wait_done(n);
        chk_write("mtlo", n, 1, 1'b1, 1'b0, 32'd31, 32'hFFFF_FFE0);
        chk_after("mtlo", 32'd31, 32'hFFFF_FFE0);

        do_accept(3'b100, 32'd1, 32'hFFFF_FFE0);
        wait_done(n);
        chk_write("madd", n, 33, 1'b1, 1'b0, 32'd31, 32'hFFFF_FFC0);
        chk_after("madd", 32'd31, 32'hFFFF_FFC0);

        do_accept(3'b101, 32'd0, 32'd5);
        wait_done(n);
        chk_write("msub", n, 33, 1'b1, 1'b0, 32'd31, 32'hFFFF_FFC0);
        chk_after("msub", 32'd31, 32'hFFFF_FFC0);

        do_accept(3'b011, 32'd100, 32'd0);
        wait_done(n);
        chk_write("divz", n, 1, 1'b0, 1'b1, 32'd0, 32'd0);
        chk_after("divz", 32'd31, 32'hFFFF_FFC0);

        // Start re-pulsed mid-CALC with a different op must be ignored
        do_accept(3'b000, 32'hFFFF_FFFE, 32'd3);
        repeat (5) @(negedge Clk);
        Start = 1'b1;
        Op = 3'b011;
        A = 32'd9;
        B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n);
        chk_write("midstart", n + 6, 33, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        chk_after("midstart", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Start held: one IDLE cycle between back-to-back ops
        @(negedge Clk);
        Start = 1'b1;
        Op = 3'b001;
        A = 32'd2;
        B = 32'd3;
        wait_done(n);
        chk_write("held1", n, 33, 1'b1, 1'b0, 32'd0, 32'd6);
        @(negedge Clk);
        chk("held_gap", {62'd0, Busy, WriteEn}, 64'd0);
        wait_done(n);
        Start = 1'b0;
        chk_write("held2", n, 33, 1'b1, 1'b0, 32'd0, 32'd6);
        chk_after("held2", 32'd0, 32'd6);

        // Reset mid-CALC aborts without writing
        do_accept(3'b000, 32'd3, 32'd3);
        repeat (10) @(negedge Clk);
        chk("rst_pre_busy", {63'd0, Busy}, 64'd1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rst_abort", {60'd0, Busy, Done, WriteEn, DivByZero}, 64'd0);
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (WriteEn || Done) we_seen++;
        end
        chk("rst_nowrite", 64'(we_seen), 64'd0);
        chk("rst_rf", {hi_rf, lo_rf}, {32'd0, 32'd6});

        do_accept(3'b000, 32'd6, 32'd7);
        wait_done(n);
        chk_write("mult67", n, 33, 1'b1, 1'b0, 32'd0, 32'd42);
        chk_after("mult67", 32'd0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
